pulse_train_gen: RTL and testbench

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_train_pkg.sv | 15 +
 rtl/dn_counter.sv | 29 ++
 rtl/pulse_train_gen.sv | 147 ++++++++++++++
 tb/tb_pulse_train_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_train_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int REP_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dn_counter.sv
// Loadable down-counter; tc flags the last cycle of a phase (count == 1).
module dn_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - ONE;
        end
    end

    assign tc = (count_reg == ONE);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: optional lead gap, then repeats x (high, low) periods.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] lead_len,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [REP_W-1:0] repeats,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] high_cfg_reg, high_cfg_next;
    logic [CNT_W-1:0] low_cfg_reg, low_cfg_next;
    logic [REP_W-1:0] rep_reg, rep_next;
    logic             err_next;
    logic             d_reg, busy_reg, done_reg, err_reg;

    logic             cnt_load, cnt_en, cnt_tc;
    logic [CNT_W-1:0] cnt_load_val;
    logic             bad_cfg;

    dn_counter #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .tc       (cnt_tc)
    );

    assign bad_cfg = (high_len == '0) || (low_len == '0) || (repeats == '0);

    // The lead length is consumed at accept by loading it straight into the phase counter.
    always_comb begin
        state_next    = state_reg;
        high_cfg_next = high_cfg_reg;
        low_cfg_next  = low_cfg_reg;
        rep_next      = rep_reg;
        err_next      = 1'b0;
        cnt_load      = 1'b0;
        cnt_en        = 1'b0;
        cnt_load_val  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (bad_cfg) begin
                        err_next = 1'b1;
                    end else begin
                        high_cfg_next = high_len;
                        low_cfg_next  = low_len;
                        rep_next      = repeats;
                        cnt_load      = 1'b1;
                        if (lead_len != '0) begin
                            state_next   = ST_LEAD;
                            cnt_load_val = lead_len;
                        end else begin
                            state_next   = ST_HIGH;
                            cnt_load_val = high_len;
                        end
                    end
                end
            end
            ST_LEAD, ST_HIGH: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (cnt_tc) begin
                    cnt_load = 1'b1;
                    if (state_reg == ST_LEAD) begin
                        state_next   = ST_HIGH;
                        cnt_load_val = high_cfg_reg;
                    end else begin
                        state_next   = ST_LOW;
                        cnt_load_val = low_cfg_reg;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (cnt_tc) begin
                    if (rep_reg == REP_ONE) begin
                        state_next = ST_DONE;
                        rep_next   = '0;
                    end else begin
                        state_next   = ST_HIGH;
                        rep_next     = rep_reg - REP_ONE;
                        cnt_load     = 1'b1;
                        cnt_load_val = high_cfg_reg;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered and glitch-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            high_cfg_reg <= '0;
            low_cfg_reg  <= '0;
            rep_reg      <= '0;
            d_reg        <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            high_cfg_reg <= high_cfg_next;
            low_cfg_reg  <= low_cfg_next;
            rep_reg      <= rep_next;
            d_reg        <= (state_next == ST_HIGH);
            busy_reg     <= (state_next == ST_LEAD) || (state_next == ST_HIGH) ||
                            (state_next == ST_LOW);
            done_reg     <= (state_next == ST_DONE);
            err_reg      <= err_next;
        end
    end

    assign d    = d_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen with narrow fields so extreme lengths stay short.
module tb_pulse_train_gen;

    localparam int CW = 8;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] lead_len = '0;
    logic [CW-1:0] high_len = '0;
    logic [CW-1:0] low_len = '0;
    logic [RW-1:0] repeats = '0;
    logic          d, busy, done, err;

    int checks = 0;
    int errors = 0;

    pulse_train_gen #(.CNT_W(CW), .REP_W(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .lead_len (lead_len),
        .high_len (high_len),
        .low_len  (low_len),
        .repeats  (repeats),
        .d        (d),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".d"}, d, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".err"}, err, 0);
    endtask

    task automatic start_train(input int ld, input int h, input int l, input int r);
        lead_len = CW'(ld);
        high_len = CW'(h);
        low_len  = CW'(l);
        repeats  = RW'(r);
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Checks cycles c0..c1 (cycle 1 = first after accept) against the train shape; ends in cycle c1+1.
    task automatic follow(input string tag, input int ld, input int h, input int l, input int r,
                          input int c0, input int c1);
        int total;
        int exp_d;
        total = ld + r * (h + l);
        for (int c = c0; c <= c1; c++) begin
            if (c <= ld || c > total) exp_d = 0;
            else exp_d = (((c - ld - 1) % (h + l)) < h) ? 1 : 0;
            chk($sformatf("%s.c%0d.d", tag, c), d, exp_d);
            chk($sformatf("%s.c%0d.busy", tag, c), busy, (c <= total) ? 1 : 0);
            chk($sformatf("%s.c%0d.done", tag, c), done, (c == total + 1) ? 1 : 0);
            chk($sformatf("%s.c%0d.err", tag, c), err, 0);
            step();
        end
    endtask

    initial begin
        int done_seen;

        // Reset state
        step();
        step();
        chk_idle("reset");
        rst = 1'b1;
        step();
        chk_idle("post_reset");

        // Nominal train, with start pulses and config changes mid-train that must be ignored
        start_train(40, 40, 40, 3);
        follow("nom", 40, 40, 40, 3, 1, 49);
        start = 1'b1; high_len = 8'd7; lead_len = 8'd0; repeats = 8'd1;
        follow("nom", 40, 40, 40, 3, 50, 52);
        start = 1'b0; high_len = 8'd40; lead_len = 8'd40; repeats = 8'd3;
        follow("nom", 40, 40, 40, 3, 53, 283);
        $display("txn nominal 40/40/40x3 checked through cycle 283");

        // Zero lead
        start_train(0, 1, 1, 2);
        follow("zlead", 0, 1, 1, 2, 1, 6);
        $display("txn zero-lead 0/1/1x2 checked");

        // Bad configurations: one err pulse, no train
        for (int k = 0; k < 3; k++) begin
            start_train(3, (k == 0) ? 0 : 2, (k == 1) ? 0 : 2, (k == 2) ? 0 : 2);
            chk($sformatf("bad%0d.err", k), err, 1);
            chk($sformatf("bad%0d.busy", k), busy, 0);
            chk($sformatf("bad%0d.d", k), d, 0);
            chk($sformatf("bad%0d.done", k), done, 0);
            step();
            chk_idle($sformatf("bad%0d.after", k));
            $display("txn bad config %0d checked", k);
        end

        // Abort and start together in IDLE: start ignored
        abort = 1'b1;
        start_train(2, 2, 2, 1);
        abort = 1'b0;
        chk_idle("abort_start_idle");
        step();
        chk_idle("abort_start_idle2");
        $display("txn abort+start in idle checked");

        // Abort during the second HIGH phase
        start_train(40, 40, 40, 3);
        follow("abt", 40, 40, 40, 3, 1, 129);
        abort = 1'b1;
        follow("abt", 40, 40, 40, 3, 130, 130);
        abort = 1'b0;
        chk_idle("abt.next");
        done_seen = 0;
        for (int c = 0; c < 200; c++) begin
            if (done || busy || d) done_seen++;
            step();
        end
        chk("abt.quiet", done_seen, 0);
        start_train(0, 1, 1, 2);
        follow("abt.rerun", 0, 1, 1, 2, 1, 6);
        $display("txn abort in second high checked");

        // Reset mid-train, with a reset glitch between edges that must have no effect
        start_train(40, 40, 40, 3);
        follow("rst", 40, 40, 40, 3, 1, 4);
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        follow("rst", 40, 40, 40, 3, 5, 9);
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_idle("rst.edge");
        step();
        chk_idle("rst.hold");
        rst = 1'b1;
        start_train(0, 1, 1, 2);
        follow("rst.rerun", 0, 1, 1, 2, 1, 6);
        $display("txn reset mid-train checked");

        // Extreme lengths
        start_train(0, 255, 255, 1);
        follow("ext", 0, 255, 255, 1, 1, 512);
        $display("txn extremes 0/255/255x1 checked");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
